// File: rtl/af_sync_fifo_param_if.sv
// Handshake and status bundle for af_sync_fifo_param.
// The producer/consumer side uses the master modport and the FIFO uses slave.
interface af_sync_fifo_param_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  Clk_En;
    logic                  Flush;
    logic                  PUSH;
    logic [DATA_WIDTH-1:0] DIN;
    logic                  POP;
    logic [DATA_WIDTH-1:0] DOUT;
    logic [CW-1:0]         Count;
    logic [3:0]            PUSH_FLAG;
    logic [3:0]            POP_FLAG;
    logic                  Almost_Full;
    logic                  Almost_Empty;
    logic                  Overflow;
    logic                  Underflow;

    modport master (
        output Clk_En, Flush, PUSH, DIN, POP,
        input  DOUT, Count, PUSH_FLAG, POP_FLAG,
        input  Almost_Full, Almost_Empty, Overflow, Underflow
    );

    modport slave (
        input  Clk_En, Flush, PUSH, DIN, POP,
        output DOUT, Count, PUSH_FLAG, POP_FLAG,
        output Almost_Full, Almost_Empty, Overflow, Underflow
    );
endinterface

// File: rtl/af_sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, 4-bit push/pop
// status flags, almost-full/empty thresholds, sticky error flags, a
// synchronous flush and an optional extra read-output register.
module af_sync_fifo_param #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int AF_LEVEL   = 4,
    parameter int AE_LEVEL   = 4,
    parameter int REG_RD     = 0
) (
    input logic                 Clk,
    input logic                 Rst,
    af_sync_fifo_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
    localparam logic [AW:0] HALF_C  = DEPTH_C >> 1;
    localparam logic [AW:0] AF_C    = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_C    = AE_LEVEL[AW:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW:0]           count;
    logic [AW:0]           free;
    logic                  full;
    logic                  empty;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  overflow;
    logic                  underflow;
    logic [DATA_WIDTH-1:0] dout;
    logic [3:0]            push_flag;
    logic [3:0]            pop_flag;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign free  = DEPTH_C - count;

    // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
    assign pop_ok  = bus.POP  && bus.Clk_En && !empty;
    assign push_ok = bus.PUSH && bus.Clk_En && (!full || pop_ok);

    // Pointer, occupancy and sticky error state; Rst and Flush both clear it.
    always_ff @(posedge Clk) begin
        if (Rst || bus.Flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (pop_ok && !push_ok) count <= count - 1'b1;
            if (bus.PUSH && bus.Clk_En && !push_ok) overflow  <= 1'b1;
            if (bus.POP  && bus.Clk_En && empty)    underflow <= 1'b1;
        end
    end

    // Storage array; contents are never reset, only the pointers are.
    always_ff @(posedge Clk) begin
        if (push_ok && !bus.Flush && !Rst) mem[wr_ptr[AW-1:0]] <= bus.DIN;
    end

    generate
        if (REG_RD == 0) begin : g_rd_direct
            // Popped word lands on DOUT at the accepting edge; Flush holds DOUT.
            always_ff @(posedge Clk) begin
                if (Rst)                         dout <= '0;
                else if (!bus.Flush && pop_ok)   dout <= mem[rd_ptr[AW-1:0]];
            end
        end else begin : g_rd_reg
            logic [DATA_WIDTH-1:0] rd_data_p1;
            logic                  vld_p1;

            // Stage p1: capture the popped word from the array.
            always_ff @(posedge Clk) begin
                if (pop_ok) rd_data_p1 <= mem[rd_ptr[AW-1:0]];
            end

            // Stage p1 valid; Rst or Flush drops an in-flight word.
            always_ff @(posedge Clk) begin
                if (Rst || bus.Flush) vld_p1 <= 1'b0;
                else                  vld_p1 <= pop_ok;
            end

            // Output register: one edge behind the capture stage.
            always_ff @(posedge Clk) begin
                if (Rst)                         dout <= '0;
                else if (!bus.Flush && vld_p1)   dout <= rd_data_p1;
            end
        end
    endgenerate

    // Status encodings from registered count and pointers; first matching rule wins.
    always_comb begin
        push_flag = 4'h3;
        pop_flag  = 4'h2;
        if (full)                 push_flag = 4'h0;
        else if (free <= AF_C)    push_flag = 4'h1;
        else if (count >= HALF_C) push_flag = 4'h2;
        else if (count == '0)     push_flag = 4'h4;
        if (empty)                pop_flag = 4'h0;
        else if (count <= AE_C)   pop_flag = 4'h1;
        else if (full)            pop_flag = 4'h4;
        else if (count >= HALF_C) pop_flag = 4'h3;
    end

    assign bus.DOUT         = dout;
    assign bus.Count        = count;
    assign bus.PUSH_FLAG    = push_flag;
    assign bus.POP_FLAG     = pop_flag;
    assign bus.Almost_Full  = (push_flag == 4'h1);
    assign bus.Almost_Empty = (pop_flag == 4'h1);
    assign bus.Overflow     = overflow;
    assign bus.Underflow    = underflow;
endmodule

// File: tb/tb_af_sync_fifo_param.sv
// Bench for af_sync_fifo_param: one REG_RD=0 and one REG_RD=1 instance
// receive identical stimulus and are compared against a queue-based model.
module tb_af_sync_fifo_param;
    localparam int DW = 16;
    localparam int D  = 16;
    localparam int AF = 4;
    localparam int AE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    af_sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(D)) bus0 ();
    af_sync_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(D)) bus1 ();

    af_sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .REG_RD(0))
        dut0 (.Clk(clk), .Rst(rst), .bus(bus0));
    af_sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .REG_RD(1))
        dut1 (.Clk(clk), .Rst(rst), .bus(bus1));

    logic [DW-1:0] q[$];
    bit            m_ovf, m_unf;
    logic [DW-1:0] dout0, dout1, pend;
    bit            pend_v;
    int            passed = 0;
    int            total  = 0;

    function automatic logic [3:0] exp_pflag(int c);
        int fr = D - c;
        if (c == D)        return 4'h0;
        if (fr <= AF)      return 4'h1;
        if (c >= D / 2)    return 4'h2;
        if (c == 0)        return 4'h4;
        return 4'h3;
    endfunction

    function automatic logic [3:0] exp_oflag(int c);
        if (c == 0)        return 4'h0;
        if (c <= AE)       return 4'h1;
        if (c == D)        return 4'h4;
        if (c >= D / 2)    return 4'h3;
        return 4'h2;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        int c = q.size();
        check("count0", 64'(bus0.Count), 64'(c));
        check("pflag0", 64'(bus0.PUSH_FLAG), 64'(exp_pflag(c)));
        check("oflag0", 64'(bus0.POP_FLAG), 64'(exp_oflag(c)));
        check("afull0", 64'(bus0.Almost_Full), 64'(exp_pflag(c) == 4'h1));
        check("aempty0", 64'(bus0.Almost_Empty), 64'(exp_oflag(c) == 4'h1));
        check("ovf0", 64'(bus0.Overflow), 64'(m_ovf));
        check("unf0", 64'(bus0.Underflow), 64'(m_unf));
        check("dout0", 64'(bus0.DOUT), 64'(dout0));
        check("count1", 64'(bus1.Count), 64'(c));
        check("pflag1", 64'(bus1.PUSH_FLAG), 64'(exp_pflag(c)));
        check("oflag1", 64'(bus1.POP_FLAG), 64'(exp_oflag(c)));
        check("ovf1", 64'(bus1.Overflow), 64'(m_ovf));
        check("unf1", 64'(bus1.Underflow), 64'(m_unf));
        check("dout1", 64'(bus1.DOUT), 64'(dout1));
    endtask

    // One clock: drive inputs, advance the model at the edge, then check just after it.
    task automatic step(bit push, logic [DW-1:0] din, bit pop,
                        bit ce = 1'b1, bit fl = 1'b0, bit r = 1'b0);
        bit pop_ok, push_ok;
        rst = r;
        bus0.Clk_En = ce; bus0.Flush = fl; bus0.PUSH = push; bus0.DIN = din; bus0.POP = pop;
        bus1.Clk_En = ce; bus1.Flush = fl; bus1.PUSH = push; bus1.DIN = din; bus1.POP = pop;
        @(posedge clk);
        if (r) begin
            q.delete(); m_ovf = 0; m_unf = 0; dout0 = '0; dout1 = '0; pend_v = 0;
        end else if (fl) begin
            q.delete(); m_ovf = 0; m_unf = 0; pend_v = 0;
        end else begin
            if (pend_v) dout1 = pend;
            pend_v = 0;
            if (ce) begin
                pop_ok  = pop && (q.size() != 0);
                push_ok = push && ((q.size() != D) || pop_ok);
                if (pop && !pop_ok)   m_unf = 1;
                if (push && !push_ok) m_ovf = 1;
                if (pop_ok) begin
                    dout0  = q.pop_front();
                    pend   = dout0;
                    pend_v = 1;
                end
                if (push_ok) q.push_back(din);
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        bit pu, po;
        q.delete(); m_ovf = 0; m_unf = 0; dout0 = '0; dout1 = '0; pend = '0; pend_v = 0;

        // Reset
        step(0, '0, 0, 1, 0, 1);
        step(0, '0, 0, 1, 0, 1);
        step(0, '0, 0);

        // Fill 0x0001..0x0010, then one rejected push
        for (int i = 1; i <= 17; i++) step(1, 16'(i), 0);

        // Drain 16 words plus one rejected pop, then let the registered output settle
        for (int i = 0; i < 17; i++) step(0, '0, 1);
        step(0, '0, 0);

        // Push and pop together while empty
        step(1, 16'hABCD, 1);
        step(0, '0, 1);
        step(0, '0, 0);

        // Fill from reset, then push and pop together while full
        step(0, '0, 0, 1, 0, 1);
        for (int i = 0; i < 16; i++) step(1, 16'($urandom), 0);
        for (int i = 0; i < 4; i++)  step(1, 16'($urandom), 1);

        // Wrap-around with occupancy held near 3
        while (q.size() > 3) step(0, '0, 1);
        for (int i = 0; i < 40; i++) begin
            pu = (q.size() < 3) ? 1'b1 : 1'($urandom);
            po = (q.size() > 3) ? 1'b1 : 1'($urandom);
            step(pu, 16'($urandom), po);
        end

        // Flush with 5 words stored and a word in flight; errors clear, DOUT holds
        step(0, '0, 0, 1, 1);
        step(0, '0, 1);
        for (int i = 0; i < 6; i++) step(1, 16'($urandom), 0);
        step(0, '0, 1);
        step(0, '0, 0, 1, 1);
        step(0, '0, 0);

        // Clock enable low with requests present: nothing changes
        step(1, 16'h1111, 0);
        for (int i = 0; i < 3; i++) step(1, 16'($urandom), 0, 0);
        step(1, 16'h2222, 1, 0);

        // Randomized soak with occasional flush, reset and enable drop
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 10) < 6, 16'($urandom), ($urandom % 10) < 4,
                 ($urandom % 10) != 0, ($urandom % 50) == 0, ($urandom % 100) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
